// File: rtl/ysyx_23060203_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060203_rd_arbiter
//
// Shares the single AXI4 memory read port between the instruction-fetch side
// (ICache refill, m0) and the load side (LSU, m1). Only one read transaction
// is outstanding at a time, and a whole burst belongs to the master that won
// the address phase. The m1 write channels pass straight through to s; the
// m0 write channels are tied off.
//
// Handshake semantics (all channels): a transfer happens on a rising clock
// edge where valid and ready are both high; valid never waits on ready, and
// the arbiter only gates ready/valid with its own state.
//
// Ports
//   clock, reset          : clock and synchronous active-high reset
//   i_m0_ar*/o_m0_arready : m0 read address channel
//   o_m0_r*/i_m0_rready   : m0 read data channel
//   o_m0_awready/wready/bvalid : m0 write tie-offs (always 0)
//   i_m1_ar*, o_m1_r* ... : m1 read channels (same shape as m0)
//   i_m1_aw*/w*/b*        : m1 write channels, passed through to s
//   o_s_*/i_s_*           : shared downstream AXI4 port
//   o_dbg_state           : current FSM state (IDLE=0 AR0=1 AR1=2 R0=3 R1=4)
//
// Parameters
//   FIXED_PRIO : 0 = round-robin on ties, 1 = m1 always wins a tie
// ---------------------------------------------------------------------------
module ysyx_23060203_rd_arbiter #(
  parameter bit FIXED_PRIO = 1'b0,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int ID_W       = 4
) (
  input  logic                clock,
  input  logic                reset,
  // m0 read address
  input  logic                i_m0_arvalid,
  output logic                o_m0_arready,
  input  logic [ADDR_W-1:0]   i_m0_araddr,
  input  logic [ID_W-1:0]     i_m0_arid,
  input  logic [7:0]          i_m0_arlen,
  input  logic [2:0]          i_m0_arsize,
  input  logic [1:0]          i_m0_arburst,
  // m0 read data
  output logic                o_m0_rvalid,
  input  logic                i_m0_rready,
  output logic [DATA_W-1:0]   o_m0_rdata,
  output logic [1:0]          o_m0_rresp,
  output logic                o_m0_rlast,
  output logic [ID_W-1:0]     o_m0_rid,
  // m0 write tie-offs
  output logic                o_m0_awready,
  output logic                o_m0_wready,
  output logic                o_m0_bvalid,
  // m1 read address
  input  logic                i_m1_arvalid,
  output logic                o_m1_arready,
  input  logic [ADDR_W-1:0]   i_m1_araddr,
  input  logic [ID_W-1:0]     i_m1_arid,
  input  logic [7:0]          i_m1_arlen,
  input  logic [2:0]          i_m1_arsize,
  input  logic [1:0]          i_m1_arburst,
  // m1 read data
  output logic                o_m1_rvalid,
  input  logic                i_m1_rready,
  output logic [DATA_W-1:0]   o_m1_rdata,
  output logic [1:0]          o_m1_rresp,
  output logic                o_m1_rlast,
  output logic [ID_W-1:0]     o_m1_rid,
  // m1 write address
  input  logic                i_m1_awvalid,
  output logic                o_m1_awready,
  input  logic [ADDR_W-1:0]   i_m1_awaddr,
  input  logic [ID_W-1:0]     i_m1_awid,
  input  logic [7:0]          i_m1_awlen,
  input  logic [2:0]          i_m1_awsize,
  input  logic [1:0]          i_m1_awburst,
  // m1 write data
  input  logic                i_m1_wvalid,
  output logic                o_m1_wready,
  input  logic [DATA_W-1:0]   i_m1_wdata,
  input  logic [DATA_W/8-1:0] i_m1_wstrb,
  input  logic                i_m1_wlast,
  // m1 write response
  output logic                o_m1_bvalid,
  input  logic                i_m1_bready,
  output logic [1:0]          o_m1_bresp,
  output logic [ID_W-1:0]     o_m1_bid,
  // s read address
  output logic                o_s_arvalid,
  input  logic                i_s_arready,
  output logic [ADDR_W-1:0]   o_s_araddr,
  output logic [ID_W-1:0]     o_s_arid,
  output logic [7:0]          o_s_arlen,
  output logic [2:0]          o_s_arsize,
  output logic [1:0]          o_s_arburst,
  // s read data
  input  logic                i_s_rvalid,
  output logic                o_s_rready,
  input  logic [DATA_W-1:0]   i_s_rdata,
  input  logic [1:0]          i_s_rresp,
  input  logic                i_s_rlast,
  input  logic [ID_W-1:0]     i_s_rid,
  // s write address
  output logic                o_s_awvalid,
  input  logic                i_s_awready,
  output logic [ADDR_W-1:0]   o_s_awaddr,
  output logic [ID_W-1:0]     o_s_awid,
  output logic [7:0]          o_s_awlen,
  output logic [2:0]          o_s_awsize,
  output logic [1:0]          o_s_awburst,
  // s write data
  output logic                o_s_wvalid,
  input  logic                i_s_wready,
  output logic [DATA_W-1:0]   o_s_wdata,
  output logic [DATA_W/8-1:0] o_s_wstrb,
  output logic                o_s_wlast,
  // s write response
  input  logic                i_s_bvalid,
  output logic                o_s_bready,
  input  logic [1:0]          i_s_bresp,
  input  logic [ID_W-1:0]     i_s_bid,
  // debug
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR0  = 3'd1,
    S_AR1  = 3'd2,
    S_R0   = 3'd3,
    S_R1   = 3'd4
  } state_t;

  state_t r_state;
  // 1 when m1 won the most recent address handshake; reset to 1 so that m0
  // wins the first tie after reset.
  logic   r_last_gnt;

  logic w_pick_m1;
  logic w_sel_m1;
  logic w_s_arvalid;
  logic w_s_rready;
  logic w_ar_hs;
  logic w_r_done;

  // m1 wins when it is alone, or on a tie when fixed priority is selected or
  // m0 was the last winner.
  assign w_pick_m1 = i_m1_arvalid &
                     (~i_m0_arvalid | FIXED_PRIO | ~r_last_gnt);

  assign w_sel_m1    = (r_state == S_AR1) || (r_state == S_R1);
  assign w_s_arvalid = ((r_state == S_AR0) & i_m0_arvalid) |
                       ((r_state == S_AR1) & i_m1_arvalid);
  assign w_s_rready  = ((r_state == S_R0) & i_m0_rready) |
                       ((r_state == S_R1) & i_m1_rready);
  assign w_ar_hs     = w_s_arvalid & i_s_arready;
  assign w_r_done    = i_s_rvalid & w_s_rready & i_s_rlast;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_m0_arvalid | i_m1_arvalid)
            r_state <= w_pick_m1 ? S_AR1 : S_AR0;
        end
        S_AR0: begin
          if (w_ar_hs) begin
            r_state    <= S_R0;
            r_last_gnt <= 1'b0;
          end
        end
        S_AR1: begin
          if (w_ar_hs) begin
            r_state    <= S_R1;
            r_last_gnt <= 1'b1;
          end
        end
        S_R0, S_R1: begin
          // Only rlast ends the burst; the beat count is not tracked.
          if (w_r_done)
            r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read address: fields follow the latched grant, so they stay stable until
  // the handshake as long as the granted master holds them.
  assign o_s_arvalid  = w_s_arvalid;
  assign o_s_araddr   = w_sel_m1 ? i_m1_araddr  : i_m0_araddr;
  assign o_s_arid     = w_sel_m1 ? i_m1_arid    : i_m0_arid;
  assign o_s_arlen    = w_sel_m1 ? i_m1_arlen   : i_m0_arlen;
  assign o_s_arsize   = w_sel_m1 ? i_m1_arsize  : i_m0_arsize;
  assign o_s_arburst  = w_sel_m1 ? i_m1_arburst : i_m0_arburst;
  assign o_m0_arready = (r_state == S_AR0) & i_s_arready;
  assign o_m1_arready = (r_state == S_AR1) & i_s_arready;

  // Read data: payload fans out to both; only the owner sees rvalid. Stray
  // beats outside R0/R1 are neither accepted nor forwarded.
  assign o_s_rready  = w_s_rready;
  assign o_m0_rvalid = (r_state == S_R0) & i_s_rvalid;
  assign o_m1_rvalid = (r_state == S_R1) & i_s_rvalid;
  assign o_m0_rdata  = i_s_rdata;
  assign o_m0_rresp  = i_s_rresp;
  assign o_m0_rlast  = i_s_rlast;
  assign o_m0_rid    = i_s_rid;
  assign o_m1_rdata  = i_s_rdata;
  assign o_m1_rresp  = i_s_rresp;
  assign o_m1_rlast  = i_s_rlast;
  assign o_m1_rid    = i_s_rid;

  // m0 never writes.
  assign o_m0_awready = 1'b0;
  assign o_m0_wready  = 1'b0;
  assign o_m0_bvalid  = 1'b0;

  // m1 write path is a straight wire to s.
  assign o_s_awvalid  = i_m1_awvalid;
  assign o_m1_awready = i_s_awready;
  assign o_s_awaddr   = i_m1_awaddr;
  assign o_s_awid     = i_m1_awid;
  assign o_s_awlen    = i_m1_awlen;
  assign o_s_awsize   = i_m1_awsize;
  assign o_s_awburst  = i_m1_awburst;
  assign o_s_wvalid   = i_m1_wvalid;
  assign o_m1_wready  = i_s_wready;
  assign o_s_wdata    = i_m1_wdata;
  assign o_s_wstrb    = i_m1_wstrb;
  assign o_s_wlast    = i_m1_wlast;
  assign o_m1_bvalid  = i_s_bvalid;
  assign o_s_bready   = i_m1_bready;
  assign o_m1_bresp   = i_s_bresp;
  assign o_m1_bid     = i_s_bid;

  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ysyx_23060203_rd_arbiter.sv
module tb_ysyx_23060203_rd_arbiter;

  localparam logic [2:0] ST_IDLE = 3'd0, ST_AR0 = 3'd1, ST_AR1 = 3'd2,
                         ST_R0 = 3'd3, ST_R1 = 3'd4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- driven inputs ----------------
  logic        m0_arvalid, m0_rready, m1_arvalid, m1_rready;
  logic [31:0] m0_araddr, m1_araddr;
  logic [3:0]  m0_arid, m1_arid;
  logic [7:0]  m0_arlen, m1_arlen;
  logic [2:0]  m0_arsize, m1_arsize;
  logic [1:0]  m0_arburst, m1_arburst;
  logic        m1_awvalid, m1_wvalid, m1_wlast, m1_bready;
  logic [31:0] m1_awaddr, m1_wdata;
  logic [3:0]  m1_awid, m1_wstrb;
  logic [7:0]  m1_awlen;
  logic [2:0]  m1_awsize;
  logic [1:0]  m1_awburst;
  logic        s_arready, s_rvalid, s_rlast, s_awready, s_wready, s_bvalid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;
  logic [3:0]  s_rid, s_bid;

  // ---------------- round-robin instance outputs ----------------
  logic        m0_arready, m0_rvalid, m0_rlast, m0_awready, m0_wready, m0_bvalid;
  logic        m1_arready, m1_rvalid, m1_rlast, m1_awready, m1_wready, m1_bvalid;
  logic [31:0] m0_rdata, m1_rdata, s_araddr, s_awaddr, s_wdata;
  logic [1:0]  m0_rresp, m1_rresp, m1_bresp, s_arburst, s_awburst;
  logic [3:0]  m0_rid, m1_rid, m1_bid, s_arid, s_awid, s_wstrb;
  logic [7:0]  s_arlen, s_awlen;
  logic [2:0]  s_arsize, s_awsize, dbg_state;
  logic        s_arvalid, s_rready, s_awvalid, s_wvalid, s_wlast, s_bready;

  // ---------------- fixed-priority instance outputs ----------------
  logic        fp_m0_arready, fp_m0_rvalid, fp_m0_rlast, fp_m0_awready, fp_m0_wready, fp_m0_bvalid;
  logic        fp_m1_arready, fp_m1_rvalid, fp_m1_rlast, fp_m1_awready, fp_m1_wready, fp_m1_bvalid;
  logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_araddr, fp_s_awaddr, fp_s_wdata;
  logic [1:0]  fp_m0_rresp, fp_m1_rresp, fp_m1_bresp, fp_s_arburst, fp_s_awburst;
  logic [3:0]  fp_m0_rid, fp_m1_rid, fp_m1_bid, fp_s_arid, fp_s_awid, fp_s_wstrb;
  logic [7:0]  fp_s_arlen, fp_s_awlen;
  logic [2:0]  fp_s_arsize, fp_s_awsize, fp_dbg_state;
  logic        fp_s_arvalid, fp_s_rready, fp_s_awvalid, fp_s_wvalid, fp_s_wlast, fp_s_bready;

  ysyx_23060203_rd_arbiter #(.FIXED_PRIO(1'b0)) u_dut (
    .clock(clk), .reset(rst),
    .i_m0_arvalid(m0_arvalid), .o_m0_arready(m0_arready), .i_m0_araddr(m0_araddr),
    .i_m0_arid(m0_arid), .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
    .o_m0_rvalid(m0_rvalid), .i_m0_rready(m0_rready), .o_m0_rdata(m0_rdata), .o_m0_rresp(m0_rresp),
    .o_m0_rlast(m0_rlast), .o_m0_rid(m0_rid),
    .o_m0_awready(m0_awready), .o_m0_wready(m0_wready), .o_m0_bvalid(m0_bvalid),
    .i_m1_arvalid(m1_arvalid), .o_m1_arready(m1_arready), .i_m1_araddr(m1_araddr),
    .i_m1_arid(m1_arid), .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
    .o_m1_rvalid(m1_rvalid), .i_m1_rready(m1_rready), .o_m1_rdata(m1_rdata), .o_m1_rresp(m1_rresp),
    .o_m1_rlast(m1_rlast), .o_m1_rid(m1_rid),
    .i_m1_awvalid(m1_awvalid), .o_m1_awready(m1_awready), .i_m1_awaddr(m1_awaddr),
    .i_m1_awid(m1_awid), .i_m1_awlen(m1_awlen), .i_m1_awsize(m1_awsize), .i_m1_awburst(m1_awburst),
    .i_m1_wvalid(m1_wvalid), .o_m1_wready(m1_wready), .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
    .i_m1_wlast(m1_wlast), .o_m1_bvalid(m1_bvalid), .i_m1_bready(m1_bready), .o_m1_bresp(m1_bresp),
    .o_m1_bid(m1_bid),
    .o_s_arvalid(s_arvalid), .i_s_arready(s_arready), .o_s_araddr(s_araddr), .o_s_arid(s_arid),
    .o_s_arlen(s_arlen), .o_s_arsize(s_arsize), .o_s_arburst(s_arburst),
    .i_s_rvalid(s_rvalid), .o_s_rready(s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
    .i_s_rlast(s_rlast), .i_s_rid(s_rid),
    .o_s_awvalid(s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(s_awaddr), .o_s_awid(s_awid),
    .o_s_awlen(s_awlen), .o_s_awsize(s_awsize), .o_s_awburst(s_awburst),
    .o_s_wvalid(s_wvalid), .i_s_wready(s_wready), .o_s_wdata(s_wdata), .o_s_wstrb(s_wstrb),
    .o_s_wlast(s_wlast), .i_s_bvalid(s_bvalid), .o_s_bready(s_bready), .i_s_bresp(s_bresp),
    .i_s_bid(s_bid), .o_dbg_state(dbg_state)
  );

  ysyx_23060203_rd_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .clock(clk), .reset(rst),
    .i_m0_arvalid(m0_arvalid), .o_m0_arready(fp_m0_arready), .i_m0_araddr(m0_araddr),
    .i_m0_arid(m0_arid), .i_m0_arlen(m0_arlen), .i_m0_arsize(m0_arsize), .i_m0_arburst(m0_arburst),
    .o_m0_rvalid(fp_m0_rvalid), .i_m0_rready(m0_rready), .o_m0_rdata(fp_m0_rdata), .o_m0_rresp(fp_m0_rresp),
    .o_m0_rlast(fp_m0_rlast), .o_m0_rid(fp_m0_rid),
    .o_m0_awready(fp_m0_awready), .o_m0_wready(fp_m0_wready), .o_m0_bvalid(fp_m0_bvalid),
    .i_m1_arvalid(m1_arvalid), .o_m1_arready(fp_m1_arready), .i_m1_araddr(m1_araddr),
    .i_m1_arid(m1_arid), .i_m1_arlen(m1_arlen), .i_m1_arsize(m1_arsize), .i_m1_arburst(m1_arburst),
    .o_m1_rvalid(fp_m1_rvalid), .i_m1_rready(m1_rready), .o_m1_rdata(fp_m1_rdata), .o_m1_rresp(fp_m1_rresp),
    .o_m1_rlast(fp_m1_rlast), .o_m1_rid(fp_m1_rid),
    .i_m1_awvalid(m1_awvalid), .o_m1_awready(fp_m1_awready), .i_m1_awaddr(m1_awaddr),
    .i_m1_awid(m1_awid), .i_m1_awlen(m1_awlen), .i_m1_awsize(m1_awsize), .i_m1_awburst(m1_awburst),
    .i_m1_wvalid(m1_wvalid), .o_m1_wready(fp_m1_wready), .i_m1_wdata(m1_wdata), .i_m1_wstrb(m1_wstrb),
    .i_m1_wlast(m1_wlast), .o_m1_bvalid(fp_m1_bvalid), .i_m1_bready(m1_bready), .o_m1_bresp(fp_m1_bresp),
    .o_m1_bid(fp_m1_bid),
    .o_s_arvalid(fp_s_arvalid), .i_s_arready(s_arready), .o_s_araddr(fp_s_araddr), .o_s_arid(fp_s_arid),
    .o_s_arlen(fp_s_arlen), .o_s_arsize(fp_s_arsize), .o_s_arburst(fp_s_arburst),
    .i_s_rvalid(s_rvalid), .o_s_rready(fp_s_rready), .i_s_rdata(s_rdata), .i_s_rresp(s_rresp),
    .i_s_rlast(s_rlast), .i_s_rid(s_rid),
    .o_s_awvalid(fp_s_awvalid), .i_s_awready(s_awready), .o_s_awaddr(fp_s_awaddr), .o_s_awid(fp_s_awid),
    .o_s_awlen(fp_s_awlen), .o_s_awsize(fp_s_awsize), .o_s_awburst(fp_s_awburst),
    .o_s_wvalid(fp_s_wvalid), .i_s_wready(s_wready), .o_s_wdata(fp_s_wdata), .o_s_wstrb(fp_s_wstrb),
    .o_s_wlast(fp_s_wlast), .i_s_bvalid(s_bvalid), .o_s_bready(fp_s_bready), .i_s_bresp(s_bresp),
    .i_s_bid(s_bid), .o_dbg_state(fp_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    m0_arvalid = 0; m0_araddr = 0; m0_arid = 4'h1; m0_arlen = 0; m0_arsize = 3'd2;
    m0_arburst = 2'b01; m0_rready = 0;
    m1_arvalid = 0; m1_araddr = 0; m1_arid = 4'h2; m1_arlen = 0; m1_arsize = 3'd2;
    m1_arburst = 2'b01; m1_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_awid = 0; m1_awlen = 0; m1_awsize = 0; m1_awburst = 0;
    m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0; m1_wlast = 0; m1_bready = 0;
    s_arready = 0; s_rvalid = 0; s_rdata = 0; s_rresp = 0; s_rlast = 0; s_rid = 4'h3;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_bresp = 0; s_bid = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    tick();
  endtask

  // One accepted read beat on the round-robin instance, owned by master `who`.
  task automatic beat(input int who, input logic [31:0] d, input logic last);
    s_rvalid = 1; s_rdata = d; s_rlast = last; m0_rready = 1; m1_rready = 1;
    #1;
    chk("beat_owner_rvalid", (who == 0) ? m0_rvalid : m1_rvalid, 1);
    chk("beat_other_rvalid", (who == 0) ? m1_rvalid : m0_rvalid, 0);
    chk("beat_rdata", (who == 0) ? m0_rdata : m1_rdata, d);
    chk("beat_rlast", (who == 0) ? m0_rlast : m1_rlast, last);
    chk("beat_s_rready", s_rready, 1);
    tick();
    s_rvalid = 0; s_rlast = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int k;
    logic [31:0] mem [4];
    idle_inputs();
    rst = 1;
    s_rvalid = 1; // stray response during reset
    tick(); tick();
    #1;
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_s_arvalid", s_arvalid, 0);
    chk("rst_s_rready", s_rready, 0);
    chk("rst_m0_rvalid", m0_rvalid, 0);
    chk("rst_m1_rvalid", m1_rvalid, 0);
    chk("rst_m0_arready", m0_arready, 0);
    rst = 0;
    s_rvalid = 0;
    tick();

    // ---- write path passthrough and m0 tie-offs ----
    m1_awvalid = 1; m1_awaddr = 32'h8000_1000; m1_awlen = 8'd2; m1_wvalid = 1;
    m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'hC; m1_wlast = 1; m1_bready = 1;
    s_awready = 1; s_wready = 1; s_bvalid = 1; s_bresp = 2'b10; s_bid = 4'h5;
    #1;
    chk("wr_awvalid", s_awvalid, 1);
    chk("wr_awaddr", s_awaddr, 32'h8000_1000);
    chk("wr_awlen", s_awlen, 8'd2);
    chk("wr_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr_wstrb", s_wstrb, 4'hC);
    chk("wr_m1_awready", m1_awready, 1);
    chk("wr_m1_bresp", m1_bresp, 2'b10);
    chk("wr_m1_bid", m1_bid, 4'h5);
    chk("wr_s_bready", s_bready, 1);
    chk("wr_m0_awready", m0_awready, 0);
    chk("wr_m0_wready", m0_wready, 0);
    chk("wr_m0_bvalid", m0_bvalid, 0);
    idle_inputs();
    tick();

    // ---- test 1: single m0 burst of 4 beats ----
    m0_arvalid = 1; m0_araddr = 32'h8000_0000; m0_arlen = 8'd3; s_arready = 1;
    #1;
    chk("t1_idle_no_arvalid", s_arvalid, 0);
    tick();
    chk("t1_state_ar0", dbg_state, ST_AR0);
    chk("t1_s_arvalid", s_arvalid, 1);
    chk("t1_s_araddr", s_araddr, 32'h8000_0000);
    chk("t1_s_arlen", s_arlen, 8'd3);
    chk("t1_s_arid", s_arid, 4'h1);
    chk("t1_m0_arready", m0_arready, 1);
    chk("t1_m1_arready", m1_arready, 0);
    tick();
    m0_arvalid = 0;
    #1;
    chk("t1_state_r0", dbg_state, ST_R0);
    chk("t1_no_ar_in_r", s_arvalid, 0);
    for (int b = 0; b < 4; b++) beat(0, 32'h1000 + b, (b == 3));
    s_rvalid = 1; // stray beat after the burst
    #1;
    chk("t1_back_idle", dbg_state, ST_IDLE);
    chk("t1_stray_rready", s_rready, 0);
    chk("t1_stray_m0_rvalid", m0_rvalid, 0);
    s_rvalid = 0;

    // ---- test 2: round-robin ties after reset ----
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0100;
    m1_arvalid = 1; m1_araddr = 32'h8000_0200; s_arready = 1;
    tick();
    chk("t2_first_ar0", dbg_state, ST_AR0);
    chk("t2_first_addr", s_araddr, 32'h8000_0100);
    chk("t2_first_m1_arready", m1_arready, 0);
    tick();
    beat(0, 32'hA0, 1);          // m0 keeps arvalid high: new tie at IDLE
    tick();
    chk("t2_second_ar1", dbg_state, ST_AR1);
    chk("t2_second_addr", s_araddr, 32'h8000_0200);
    chk("t2_second_m1_arready", m1_arready, 1);
    chk("t2_second_m0_arready", m0_arready, 0);
    tick();
    beat(1, 32'hA1, 1);          // both still high: tie again
    tick();
    chk("t2_third_ar0", dbg_state, ST_AR0);
    chk("t2_third_addr", s_araddr, 32'h8000_0100);
    tick();
    m0_arvalid = 0; m1_arvalid = 0;
    beat(0, 32'hA2, 1);

    // ---- test 3: fixed priority, three ties then m0 alone ----
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0300;
    m1_arvalid = 1; m1_araddr = 32'h8000_0400; s_arready = 1;
    for (int r = 0; r < 3; r++) begin
      tick();
      chk("t3_tie_ar1", fp_dbg_state, ST_AR1);
      chk("t3_tie_addr", fp_s_araddr, 32'h8000_0400);
      chk("t3_tie_m1_arready", fp_m1_arready, 1);
      chk("t3_tie_m0_arready", fp_m0_arready, 0);
      tick();
      s_rvalid = 1; s_rdata = 32'hB0 + r; s_rlast = 1; m1_rready = 1; m0_rready = 1;
      #1;
      chk("t3_m1_rvalid", fp_m1_rvalid, 1);
      chk("t3_m0_rvalid", fp_m0_rvalid, 0);
      tick();
      s_rvalid = 0; s_rlast = 0;
    end
    m1_arvalid = 0;
    tick();
    chk("t3_m0_alone_ar0", fp_dbg_state, ST_AR0);
    chk("t3_m0_alone_addr", fp_s_araddr, 32'h8000_0300);
    tick();
    m0_arvalid = 0;
    s_rvalid = 1; s_rlast = 1; #1;
    chk("t3_m0_rvalid", fp_m0_rvalid, 1);
    tick();
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t3_fp_idle", fp_dbg_state, ST_IDLE);

    // ---- test 4: arready held low for 5 cycles ----
    idle_inputs();
    do_reset();
    m0_arvalid = 1; m0_araddr = 32'h8000_0500; m0_arlen = 8'd0;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_arvalid", s_arvalid, 1);
      chk("t4_hold_araddr", s_araddr, 32'h8000_0500);
      chk("t4_hold_m0_arready", m0_arready, 0);
      tick();
    end
    s_arready = 1;
    #1;
    chk("t4_hs_m0_arready", m0_arready, 1);
    tick();
    m0_arvalid = 0;
    #1;
    chk("t4_state_r0", dbg_state, ST_R0);
    beat(0, 32'hC0, 1);

    // ---- test 5: reset during beat 2 of a 4-beat burst ----
    m0_arvalid = 1; m0_araddr = 32'h8000_0600; m0_arlen = 8'd3;
    tick(); tick();
    m0_arvalid = 0;
    beat(0, 32'hD0, 0);
    s_rvalid = 1; s_rdata = 32'hD1; m0_rready = 1; rst = 1;
    tick();
    chk("t5_rst_idle", dbg_state, ST_IDLE);
    chk("t5_rst_m0_rvalid", m0_rvalid, 0);
    chk("t5_rst_s_rready", s_rready, 0);
    rst = 0;
    tick();
    chk("t5_after_m0_rvalid", m0_rvalid, 0);
    s_rvalid = 0;
    m0_arvalid = 1; m1_arvalid = 1; m1_araddr = 32'h8000_0700;
    tick();
    chk("t5_tie_to_m0", dbg_state, ST_AR0);
    tick();
    m0_arvalid = 0;
    beat(0, 32'hD4, 1);
    tick();                       // m1 still waiting: granted now
    chk("t5_loser_served", dbg_state, ST_AR1);
    tick();
    m1_arvalid = 0;
    beat(1, 32'hD5, 1);

    // ---- test 6: m0 rready low for 3 cycles mid-burst ----
    do_reset();
    mem[0] = 32'hE0; mem[1] = 32'hE1; mem[2] = 32'hE2; mem[3] = 32'hE3;
    for (int b = 0; b < 4; b++) exp_q.push_back(mem[b]);
    m0_arvalid = 1; m0_araddr = 32'h8000_0800; m0_arlen = 8'd3;
    tick(); tick();
    m0_arvalid = 0;
    k = 0;
    for (int c = 0; c < 12 && k < 4; c++) begin
      m0_rready = !(c >= 1 && c <= 3);
      s_rvalid = 1; s_rdata = mem[k]; s_rlast = (k == 3);
      #1;
      chk("t6_s_rready_follows", s_rready, m0_rready);
      if (m0_rvalid && m0_rready) chk("t6_rdata", m0_rdata, exp_q.pop_front());
      if (s_rready) k++;
      tick();
    end
    s_rvalid = 0; s_rlast = 0;
    #1;
    chk("t6_beats_consumed", k, 4);
    chk("t6_queue_empty", exp_q.size(), 0);
    chk("t6_back_idle", dbg_state, ST_IDLE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
